// File: rtl/an_residue_barrett_n13_pkg.sv
// Shared AN-code constants and stage types (A=13, 6-bit codewords).
// The downstream decoder imports the same package so both sides agree on A and widths.
package an_code_pkg;
    localparam int unsigned N     = 6;
    localparam int unsigned A     = 13;
    localparam int unsigned K     = 2 * N;
    localparam int unsigned MU    = (2 ** K) / A;
    localparam int unsigned MU_W  = $clog2(MU + 1);
    localparam int unsigned P_W   = N + MU_W;
    localparam int unsigned R_W   = $clog2(A);
    localparam int unsigned CNT_W = 8;

    typedef logic [N-1:0]   codeword_t;
    typedef logic [R_W-1:0] residue_t;

    typedef struct packed {
        logic           valid;
        codeword_t      x;
        logic [P_W-1:0] p;
    } s1_t;

    typedef struct packed {
        logic         valid;
        codeword_t    x;
        logic [R_W:0] t;
    } s2_t;
endpackage

// File: rtl/an_residue_barrett_n13_if.sv
// Codeword-in / residue-out handshake bundle for the Barrett residue stage.
interface an_residue_barrett_n13_if;
    import an_code_pkg::*;

    logic      in_valid;
    logic      in_ready;
    codeword_t in_codeword;
    logic      out_valid;
    logic      out_ready;
    codeword_t out_codeword;
    residue_t  out_residue;
    logic      out_err;

    modport master (
        output in_valid, in_codeword, out_ready,
        input  in_ready, out_valid, out_codeword, out_residue, out_err
    );

    modport slave (
        input  in_valid, in_codeword, out_ready,
        output in_ready, out_valid, out_codeword, out_residue, out_err
    );
endinterface

// File: rtl/an_residue_barrett_n13_reduce.sv
// Combinational Barrett datapath: S2 quotient/subtract and S3 single conditional correction.
module an_barrett_reduce #(
    parameter  int unsigned N    = 6,
    parameter  int unsigned A    = 13,
    parameter  int unsigned K    = 2 * N,
    localparam int unsigned MU   = (2 ** K) / A,
    localparam int unsigned MU_W = $clog2(MU + 1),
    localparam int unsigned P_W  = N + MU_W,
    localparam int unsigned R_W  = $clog2(A)
) (
    input  logic [N-1:0]   x,
    input  logic [P_W-1:0] p,
    output logic [R_W:0]   t,
    input  logic [R_W:0]   t_reg,
    output logic [R_W-1:0] r
);
    localparam int unsigned Q_W = P_W - K;
    localparam logic [N-1:0] A_N = N'(A);
    localparam logic [R_W:0] A_T = (R_W + 1)'(A);

    logic [Q_W-1:0] q;
    logic [N-1:0]   qa;

    // q never exceeds floor(x/A), so q*A fits in N bits and t lands in 0..2A-1
    always_comb begin
        q  = Q_W'(p >> K);
        qa = N'(q) * A_N;
        t  = (R_W + 1)'(x - qa);
    end

    always_comb begin
        r = R_W'((t_reg >= A_T) ? (t_reg - A_T) : t_reg);
    end
endmodule

// File: rtl/an_residue_barrett_n13.sv
// Three-stage Barrett residue generator (codeword mod 13) with error flag and saturating count.
module an_residue_barrett_n13
    import an_code_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    an_residue_barrett_n13_if.slave   bus,
    input  logic                      clr_cnt,
    output logic [CNT_W-1:0]          err_cnt
);
    s1_t            s1;
    s2_t            s2;
    logic [P_W-1:0] p_nxt;
    logic [R_W:0]   t_nxt;
    residue_t       r_nxt;
    logic           stall;

    // Stall depends only on registered out_valid, never on in_valid
    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;
    assign p_nxt        = P_W'(bus.in_codeword) * P_W'(MU);

    an_barrett_reduce #(
        .N (N),
        .A (A),
        .K (K)
    ) u_reduce (
        .x     (s1.x),
        .p     (s1.p),
        .t     (t_nxt),
        .t_reg (s2.t),
        .r     (r_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1               <= '0;
            s2               <= '0;
            bus.out_valid    <= 1'b0;
            bus.out_codeword <= '0;
            bus.out_residue  <= '0;
            bus.out_err      <= 1'b0;
        end else if (!stall) begin
            s1.valid         <= bus.in_valid;
            s1.x             <= bus.in_codeword;
            s1.p             <= p_nxt;
            s2.valid         <= s1.valid;
            s2.x             <= s1.x;
            s2.t             <= t_nxt;
            bus.out_valid    <= s2.valid;
            bus.out_codeword <= s2.x;
            bus.out_residue  <= r_nxt;
            bus.out_err      <= (r_nxt != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready && bus.out_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_an_residue_barrett_n13.sv
// Randomised and directed bench for an_residue_barrett_n13 against a queue-based mod-13 model.
module tb_an_residue_barrett_n13;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_cnt = 1'b0;
    logic [7:0] err_cnt;

    an_residue_barrett_n13_if bus ();

    an_residue_barrett_n13 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .clr_cnt (clr_cnt),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned expq[$];
    int unsigned exp_cnt = 0;
    int unsigned mon_x;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: every transfer is observed at the falling edge, where all signals are settled
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            exp_cnt = 0;
        end else begin
            check("err_cnt", 32'(err_cnt), exp_cnt);
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    check("spurious_out", 32'(bus.out_codeword), 32'hFFFF_FFFF);
                end else begin
                    mon_x = expq.pop_front();
                    check("out_codeword", 32'(bus.out_codeword), mon_x);
                    check("out_residue", 32'(bus.out_residue), mon_x % 13);
                    check("out_err", 32'(bus.out_err), 32'((mon_x % 13) != 0));
                    if ((mon_x % 13) != 0 && exp_cnt < 255) exp_cnt++;
                end
            end
            if (bus.in_valid && bus.in_ready) expq.push_back(32'(bus.in_codeword));
            if (clr_cnt) exp_cnt = 0;
        end
    end

    task automatic push(input int unsigned x);
        int unsigned n  = 0;
        logic        ok = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_codeword = 6'(x);
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            n++;
        end while (!ok && n < 200);
        if (!ok) check("push_ready", 32'(ok), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        bus.out_ready = 1'b1;
        while ((expq.size() != 0 || bus.out_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", 32'(n < 500), 1);
    endtask

    task automatic latency_push(input int unsigned x);
        int unsigned n = 1;
        push(x);
        while (!bus.out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, 3);
    endtask

    initial begin
        int unsigned sent;
        int unsigned cyc;
        int unsigned n;

        bus.in_valid    = 1'b0;
        bus.in_codeword = '0;
        bus.out_ready   = 1'b1;
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_codeword", 32'(bus.out_codeword), 0);
        check("rst_out_residue", 32'(bus.out_residue), 0);
        check("rst_out_err", 32'(bus.out_err), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 32'(bus.in_ready), 1);

        // Full codeword sweep
        latency_push(0);
        for (int unsigned x = 1; x < 64; x++) push(x);
        drain();
        check("sweep_err_cnt", 32'(err_cnt), 59);

        // Stall with three words in flight
        bus.out_ready = 1'b0;
        push(5);
        push(14);
        push(27);
        for (int i = 0; i < 4; i++) begin
            check("stall_out_valid", 32'(bus.out_valid), 1);
            check("stall_in_ready", 32'(bus.in_ready), 0);
            check("stall_codeword", 32'(bus.out_codeword), 5);
            check("stall_residue", 32'(bus.out_residue), 5);
            @(posedge clk);
            #1;
        end
        drain();
        check("stall_err_cnt", 32'(err_cnt), 62);

        // Random handshake traffic
        sent = 0;
        cyc  = 0;
        while (sent < 10000 && cyc < 60000) begin
            bus.in_valid    = 1'($urandom_range(0, 1));
            bus.in_codeword = 6'($urandom_range(0, 63));
            bus.out_ready   = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("random_sent", sent, 10000);
        drain();

        // Saturation, then clear coinciding with an erroneous transfer
        for (int unsigned i = 0; i < 300; i++) push(1);
        drain();
        check("sat_err_cnt", 32'(err_cnt), 255);
        push(1);
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("clr_setup_valid", 32'(bus.out_valid), 1);
        check("clr_setup_err", 32'(bus.out_err), 1);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check("clr_wins", 32'(err_cnt), 0);
        drain();

        // Asynchronous reset with words in flight
        push(1);
        push(2);
        push(3);
        check("inflight_valid", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 0);
        check("async_rst_cnt", 32'(err_cnt), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("no_stale_out", 32'(bus.out_valid), 0);
        end
        latency_push(26);
        check("post_rst_residue", 32'(bus.out_residue), 0);
        check("post_rst_codeword", 32'(bus.out_codeword), 26);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
